// File: rtl/odd_even_gen.sv
// Odd/even number sequence generator with a valid/ready output stream.
// Optional checking outputs (is_even_tag, parity_err) are enabled by defining ODD_EVEN_GEN_CHECK_EN.
module odd_even_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             want_even,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] number,
    output logic             num_valid,
    input  logic             num_ready,
    output logic             busy,
    output logic             done
`ifdef ODD_EVEN_GEN_CHECK_EN
    ,
    output logic             is_even_tag,
    output logic             parity_err
`endif
);

    // Handshake: a value transfers on a rising edge where num_valid and num_ready
    // are both 1; number and num_valid never change while num_valid=1 and num_ready=0.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] number_d;
    logic             num_valid_d;
    logic             xfer;

    assign xfer = num_valid & num_ready;
    assign busy = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        number_d    = number;
        num_valid_d = num_valid;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d     = SEND;
                        remaining_d = count;
                        num_valid_d = 1'b1;
                        // bit 0 already matches when it differs from want_even (even wants 0)
                        number_d    = (start_value[0] != want_even) ? start_value
                                                                    : start_value + WIDTH'(1);
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    remaining_d = remaining_q - WIDTH'(1);
                    if (remaining_q == WIDTH'(1)) begin
                        num_valid_d = 1'b0;
                        state_d     = FIN;
                    end else begin
                        number_d = number + WIDTH'(2);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                num_valid_d = 1'b0;
            end
        endcase
    end

    // done is high for the single cycle the FSM spends in FIN
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            number      <= '0;
            num_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            number      <= number_d;
            num_valid   <= num_valid_d;
            done        <= (state_d == FIN);
        end
    end

`ifdef ODD_EVEN_GEN_CHECK_EN
    logic want_even_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            want_even_q <= 1'b0;
            is_even_tag <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                want_even_q <= want_even;
            end
            is_even_tag <= num_valid_d & ~number_d[0];
            if (xfer && (number[0] == want_even_q)) begin
                parity_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_odd_even_gen.sv
// Self-checking bench for odd_even_gen: scoreboard of expected numbers, directed and random sequences.
// Define ODD_EVEN_GEN_CHECK_EN to also exercise is_even_tag and parity_err.
module tb_odd_even_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         want_even;
    logic [W-1:0] start_value;
    logic [W-1:0] count;
    logic [W-1:0] number;
    logic         num_valid;
    logic         num_ready;
    logic         busy;
    logic         done;
`ifdef ODD_EVEN_GEN_CHECK_EN
    logic         is_even_tag;
    logic         parity_err;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    int           done_cnt = 0;
    logic         cur_we   = 1'b0;
    logic [W-1:0] exp_q[$];

    odd_even_gen #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .want_even   (want_even),
        .start_value (start_value),
        .count       (count),
        .number      (number),
        .num_valid   (num_valid),
        .num_ready   (num_ready),
        .busy        (busy),
        .done        (done)
`ifdef ODD_EVEN_GEN_CHECK_EN
        ,
        .is_even_tag (is_even_tag),
        .parity_err  (parity_err)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // scoreboard: pop one expected value per observed transfer
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (num_valid && num_ready) begin
                check("xfer_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("number", number, exp_q.pop_front());
            end
`ifdef ODD_EVEN_GEN_CHECK_EN
            if (num_valid) check("is_even_tag", is_even_tag, cur_we);
`endif
        end
    end

    // driver tasks: called at posedge+1, return at posedge+1
    task automatic launch(input logic we, input logic [W-1:0] sv, input logic [W-1:0] cnt);
        logic [W-1:0] n;
        n = sv;
        if (n[0] == we) n = n + 8'd1;
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back(n);
            n = n + 8'd2;
        end
        cur_we      = we;
        start       = 1'b1;
        want_even   = we;
        start_value = sv;
        count       = cnt;
        @(posedge clk); #1;
        start       = 1'b0;
        want_even   = 1'($urandom_range(0, 1));
        start_value = W'($urandom_range(0, 255));
        count       = W'($urandom_range(0, 255));
    endtask

    task automatic wait_done(input bit timed, input int exp_lat, input bit rand_ready);
        int cycles = 0;
        bit got = 0;
        while (!got && cycles < 300) begin
            @(negedge clk);
            if (done) got = 1;
            else begin
                check("busy_during_seq", busy, 1);
                cycles++;
                if (rand_ready) begin
                    @(posedge clk); #1;
                    num_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        check("done_seen", got, 1);
        if (timed) check("done_latency", cycles, exp_lat);
        check("busy_at_done", busy, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("all_values_sent", exp_q.size(), 0);
        @(posedge clk); #1;
        num_ready = 1'b1;
    endtask

    initial begin : watchdog
        #500us;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; want_even = 1'b0;
        start_value = '0; count = '0; num_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_number", number, 0);
        check("rst_valid", num_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // even 6,8,10 with ready held high
        launch(1'b1, 8'd6, 8'd3);
        wait_done(1, 3, 0);
        // odd from 10 -> 11,13
        launch(1'b0, 8'd10, 8'd2);
        wait_done(1, 2, 0);
        // wrap cases
        launch(1'b0, 8'd253, 8'd3);
        wait_done(1, 3, 0);
        launch(1'b1, 8'd255, 8'd1);
        wait_done(1, 1, 0);
        // count = 0: no valid, done straight after start
        launch(1'b1, 8'd40, 8'd0);
        check("cnt0_no_valid", num_valid, 0);
        wait_done(1, 0, 0);

        // stall for 4 cycles mid-sequence while start is pulsed
        launch(1'b0, 8'd20, 8'd5);
        @(posedge clk); #1;
        num_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_number", number, 23);
            check("stall_valid", num_valid, 1);
            @(posedge clk); #1;
            start       = (i == 1);
            want_even   = 1'b1;
            start_value = 8'd100;
            count       = 8'd9;
        end
        start     = 1'b0;
        num_ready = 1'b1;
        wait_done(0, 0, 0);

        // reset during SEND after two transfers
        d0 = done_cnt;
        launch(1'b1, 8'd6, 8'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        check("pre_reset_left", exp_q.size(), 3);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_number", number, 0);
        check("rst_mid_valid", num_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", done_cnt, d0);
        @(posedge clk); #1;

        // random sequences with random backpressure
        for (int k = 0; k < 12; k++) begin
            launch(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)), W'($urandom_range(0, 6)));
            num_ready = 1'($urandom_range(0, 1));
            wait_done(0, 0, 1);
        end

`ifdef ODD_EVEN_GEN_CHECK_EN
        check("parity_err", parity_err, 0);
`endif
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
